// File: rtl/mvi_ctrl_if.sv
// mvi_ctrl_if -- instruction-side inputs and register-file write port of the
// move-immediate controller, bundled so the controller and its driver share
// one declaration.
//   master : the instruction source / environment (drives opcode, dest, imm)
//   slave  : the mvi_ctrl block itself
interface mvi_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              drop;
  logic              pend;

  modport master (
    output opcode, dest, imm,
    input  wr_en, wr_addr, wr_data, busy, done, drop, pend
  );

  modport slave (
    input  opcode, dest, imm,
    output wr_en, wr_addr, wr_data, busy, done, drop, pend
  );
endinterface

// File: rtl/mvi_ctrl.sv
// mvi_ctrl -- move-immediate controller.
// A request (opcode == OPC_MVI on a rising edge) taken in IDLE captures
// dest/imm, pulses one register-file write (LOAD), keeps busy for HOLD_CYC
// further cycles (HOLD), then pulses done with busy low (DONE).
// Requests that arrive while a move is in flight are dropped, unless the
// build defines MVI_PENDING_EN, which adds a one-deep pending slot that is
// issued straight out of DONE.  All outputs are registered.
module mvi_ctrl #(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 3,
  parameter int          HOLD_CYC = 3,       // 0..255
  parameter logic [3:0]  OPC_MVI  = 4'b1100
) (
  input logic        clk,
  input logic        rst_n,
  mvi_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_DONE
  } state_t;

  // Counter value loaded on LOAD -> HOLD so that HOLD spans HOLD_CYC cycles.
  localparam logic [7:0] HOLD_LAST = (HOLD_CYC > 0) ? 8'(HOLD_CYC - 1) : 8'd0;

  state_t            state;
  logic [7:0]        hold_cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              drop_q;

  logic              req;
  logic              start;       // begin a move (enter LOAD) on this edge
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] start_data;
  logic              slot_drop;   // request arriving this edge is discarded

  assign req = (bus.opcode == OPC_MVI);

`ifdef MVI_PENDING_EN
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              slot_load;   // request arriving this edge goes to the slot

  // Decide whether a move starts and where an incoming request goes.
  // A slot drained on this edge (IDLE/DONE with pend_q) may be refilled at once.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    start      = 1'b0;
    start_addr = bus.dest;
    start_data = bus.imm;
    slot_load  = 1'b0;
    slot_drop  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_q) begin
          start      = 1'b1;
          start_addr = pend_addr;
          start_data = pend_data;
          slot_load  = req;
        end else begin
          start = req;
        end
      end
      S_DONE: begin
        if (pend_q) begin
          start      = 1'b1;
          start_addr = pend_addr;
          start_data = pend_data;
        end
        slot_load = req;
      end
      default: begin
        slot_load = req && !pend_q;
        slot_drop = req &&  pend_q;
      end
    endcase
  end

  // One-deep pending slot: fill on overlap, clear when issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      // NOTE: the slot payload is reset along with its valid bit so no X can
      // ever be copied onto wr_addr/wr_data.
      pend_addr <= '0;
      pend_data <= '0;
    end else if (slot_load) begin
      pend_q    <= 1'b1;
      pend_addr <= bus.dest;
      pend_data <= bus.imm;
    end else if (start && pend_q) begin
      pend_q <= 1'b0;
    end
  end

  assign bus.pend = pend_q;
`else
  // Decide whether a move starts; anything arriving mid-move is discarded.
  always_comb begin
    start      = (state == S_IDLE) && req;
    start_addr = bus.dest;
    start_data = bus.imm;
    slot_drop  = req && (state != S_IDLE);
  end

  assign bus.pend = 1'b0;
`endif

  // Main sequencer: state, hold counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the pre-edge values and later defaults can be overridden.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= slot_drop;
      if (start) begin
        state     <= S_LOAD;
        wr_en_q   <= 1'b1;
        wr_addr_q <= start_addr;
        wr_data_q <= start_data;
        busy_q    <= 1'b1;
      end else begin
        case (state)
          S_LOAD: begin
            if (HOLD_CYC == 0) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_LAST;
            end
          end
          S_HOLD: begin
            if (hold_cnt == 8'd0) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 8'd1;
            end
          end
          default: state <= S_IDLE;  // DONE with nothing pending, or IDLE
        endcase
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.drop    = drop_q;

endmodule

// File: tb/tb_mvi_ctrl.sv
// tb_mvi_ctrl -- self-checking bench for mvi_ctrl.
// Two instances: dut_a with HOLD_CYC=0, dut_b with HOLD_CYC=3.  A directed
// table, hand-written overlap/reset sequences and a randomized run checked
// against a move-age reference model.  Honors MVI_PENDING_EN like the RTL.
module tb_mvi_ctrl;
  localparam int         DW  = 8;
  localparam int         AW  = 3;
  localparam logic [3:0] OPC = 4'b1100;
`ifdef MVI_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mvi_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
  mvi_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

  mvi_ctrl #(.DATA_W(DW), .ADDR_W(AW), .HOLD_CYC(0), .OPC_MVI(OPC)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  mvi_ctrl #(.DATA_W(DW), .ADDR_W(AW), .HOLD_CYC(3), .OPC_MVI(OPC)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          drop;
    logic          pend;
  } outs_t;

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] d;
    logic [DW-1:0] im;
    outs_t         exp;
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic outs_t sample(int k);
    outs_t o;
    if (k == 0) o = '{if_a.wr_en, if_a.wr_addr, if_a.wr_data, if_a.busy, if_a.done, if_a.drop, if_a.pend};
    else        o = '{if_b.wr_en, if_b.wr_addr, if_b.wr_data, if_b.busy, if_b.done, if_b.drop, if_b.pend};
    return o;
  endfunction

  task automatic check_outs(string tag, int k, outs_t exp);
    outs_t o = sample(k);
    check($sformatf("%s.wr_en",   tag), 32'(o.wr_en),   32'(exp.wr_en));
    check($sformatf("%s.wr_addr", tag), 32'(o.wr_addr), 32'(exp.wr_addr));
    check($sformatf("%s.wr_data", tag), 32'(o.wr_data), 32'(exp.wr_data));
    check($sformatf("%s.busy",    tag), 32'(o.busy),    32'(exp.busy));
    check($sformatf("%s.done",    tag), 32'(o.done),    32'(exp.done));
    check($sformatf("%s.drop",    tag), 32'(o.drop),    32'(exp.drop));
    check($sformatf("%s.pend",    tag), 32'(o.pend),    32'(exp.pend));
  endtask

  function automatic outs_t mko(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                logic busy, logic done, logic drop);
    return '{we, wa, wd, busy, done, drop, 1'b0};
  endfunction

  task automatic drive(int k, logic [3:0] op, logic [AW-1:0] d, logic [DW-1:0] im);
    if (k == 0) begin if_a.opcode = op; if_a.dest = d; if_a.imm = im; end
    else        begin if_b.opcode = op; if_b.dest = d; if_b.imm = im; end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Each instance tracks the age of its current move: -1 idle, 0 write
  // cycle, 1..HOLD holding, HOLD+1 completion cycle.
  int            hold_of [2] = '{0, 3};
  int            age     [2];
  bit            slot_v  [2];
  logic [AW-1:0] slot_a  [2];
  logic [DW-1:0] slot_d  [2];
  logic [AW-1:0] last_a  [2];
  logic [DW-1:0] last_d  [2];
  bit            drp     [2];

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      age[k] = -1; slot_v[k] = 0; slot_a[k] = '0; slot_d[k] = '0;
      last_a[k] = '0; last_d[k] = '0; drp[k] = 0;
    end
  endtask

  task automatic model_step(int k, logic [3:0] op, logic [AW-1:0] d, logic [DW-1:0] im);
    bit req = (op == OPC);
    int a   = age[k];
    drp[k] = 0;
    if (a < 0 || a == hold_of[k] + 1) begin
      if (slot_v[k]) begin
        age[k] = 0; last_a[k] = slot_a[k]; last_d[k] = slot_d[k]; slot_v[k] = 0;
        if (req) begin slot_v[k] = 1; slot_a[k] = d; slot_d[k] = im; end
      end else if (a < 0 && req) begin
        age[k] = 0; last_a[k] = d; last_d[k] = im;
      end else begin
        age[k] = -1;
        if (req) begin
          if (PEND_EN) begin slot_v[k] = 1; slot_a[k] = d; slot_d[k] = im; end
          else drp[k] = 1;
        end
      end
    end else begin
      age[k] = a + 1;
      if (req) begin
        if (PEND_EN && !slot_v[k]) begin slot_v[k] = 1; slot_a[k] = d; slot_d[k] = im; end
        else drp[k] = 1;
      end
    end
  endtask

  function automatic outs_t model_outs(int k);
    outs_t o;
    o.wr_en   = (age[k] == 0);
    o.wr_addr = last_a[k];
    o.wr_data = last_d[k];
    o.busy    = (age[k] >= 0) && (age[k] <= hold_of[k]);
    o.done    = (age[k] == hold_of[k] + 1);
    o.drop    = drp[k];
    o.pend    = slot_v[k];
    return o;
  endfunction

  // ---------------- overlap sequence on dut_b ----------------
  int            n_wr, n_done, n_drop, n_pend;
  logic [10:0]   wlog [2];

  task automatic run_overlap(int n);
    int            offs [3] = '{0, 2, 3};
    logic [AW-1:0] ds   [3] = '{3'd1, 3'd3, 3'd4};
    logic [DW-1:0] ims  [3] = '{8'h11, 8'h33, 8'h44};
    outs_t         o;
    n_wr = 0; n_done = 0; n_drop = 0; n_pend = 0; wlog[0] = '0; wlog[1] = '0;
    for (int c = 0; c < 25; c++) begin
      drive(1, 4'h0, '0, '0);
      for (int i = 0; i < n; i++)
        if (c == offs[i]) drive(1, OPC, ds[i], ims[i]);
      tick();
      o = sample(1);
      if (o.wr_en) begin
        if (n_wr < 2) wlog[n_wr] = {o.wr_addr, o.wr_data};
        n_wr++;
      end
      n_done += int'(o.done);
      n_drop += int'(o.drop);
      n_pend += int'(o.pend);
    end
  endtask

  vec_t          tbl [16];
  logic [3:0]    op_r [2];
  logic [AW-1:0] d_r  [2];
  logic [DW-1:0] im_r [2];

  initial begin
    int cnt;
    rst_n = 1'b0;
    drive(0, 4'h0, '0, '0);
    drive(1, 4'h0, '0, '0);
    tick();
    tick();
    check_outs("reset_a", 0, '0);
    check_outs("reset_b", 1, '0);
    rst_n = 1'b1;

    // Directed table on dut_b: first request right after reset release,
    // then ten cycles of a foreign opcode.
    tbl[0] = '{OPC,  3'd5, 8'hA7, mko(1, 3'd5, 8'hA7, 1, 0, 0)};
    for (int i = 1; i <= 3; i++)
      tbl[i] = '{4'h0, 3'd0, 8'h00, mko(0, 3'd5, 8'hA7, 1, 0, 0)};
    tbl[4] = '{4'h0, 3'd0, 8'h00, mko(0, 3'd5, 8'hA7, 0, 1, 0)};
    tbl[5] = '{4'h0, 3'd0, 8'h00, mko(0, 3'd5, 8'hA7, 0, 0, 0)};
    for (int i = 6; i < 16; i++)
      tbl[i] = '{4'b0011, 3'(i), 8'(i * 7), mko(0, 3'd5, 8'hA7, 0, 0, 0)};
    for (int i = 0; i < 16; i++) begin
      drive(1, tbl[i].op, tbl[i].d, tbl[i].im);
      tick();
      check_outs($sformatf("tbl[%0d]", i), 1, tbl[i].exp);
    end

    // HOLD_CYC=0: write and done on consecutive cycles, busy one cycle.
    drive(0, OPC, 3'd2, 8'h01);
    tick();
    check_outs("h0.load", 0, mko(1, 3'd2, 8'h01, 1, 0, 0));
    drive(0, 4'h0, '0, '0);
    tick();
    check_outs("h0.done", 0, mko(0, 3'd2, 8'h01, 0, 1, 0));
    tick();
    check_outs("h0.idle", 0, mko(0, 3'd2, 8'h01, 0, 0, 0));

    // Two overlapping requests, then three.
    run_overlap(2);
    check("ovl2.writes", 32'(n_wr), PEND_EN ? 32'd2 : 32'd1);
    check("ovl2.write0", 32'(wlog[0]), 32'({3'd1, 8'h11}));
    check("ovl2.done",   32'(n_done), PEND_EN ? 32'd2 : 32'd1);
    check("ovl2.drop",   32'(n_drop), PEND_EN ? 32'd0 : 32'd1);
    check("ovl2.pend_seen", 32'(n_pend != 0), 32'(PEND_EN));
`ifdef MVI_PENDING_EN
    check("ovl2.write1", 32'(wlog[1]), 32'({3'd3, 8'h33}));
`endif
    run_overlap(3);
    check("ovl3.writes", 32'(n_wr), PEND_EN ? 32'd2 : 32'd1);
    check("ovl3.drop",   32'(n_drop), PEND_EN ? 32'd1 : 32'd2);
    check("ovl3.done",   32'(n_done), PEND_EN ? 32'd2 : 32'd1);

    // Reset during HOLD aborts the move; a later request completes normally.
    drive(1, OPC, 3'd6, 8'hFF);
    tick();
    drive(1, 4'h0, '0, '0);
    tick();
    check("rst_mid.busy_before", 32'(if_b.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outs("rst_mid", 1, '0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(if_b.wr_en) + int'(if_b.done) + int'(if_b.busy);
    end
    check("rst_mid.quiet", 32'(cnt), 32'd0);
    drive(1, OPC, 3'd2, 8'h5A);
    tick();
    check_outs("post_rst.load", 1, mko(1, 3'd2, 8'h5A, 1, 0, 0));
    drive(1, 4'h0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outs($sformatf("post_rst[%0d]", i), 1, mko(0, 3'd2, 8'h5A, i < 3, i == 3, 0));
    end

    // Randomized run against the reference model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outs("rnd_rst_a", 0, model_outs(0));
        check_outs("rnd_rst_b", 1, model_outs(1));
        tick();
        rst_n = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        op_r[k] = ($urandom_range(0, 99) < 35) ? OPC : 4'($urandom_range(0, 15));
        d_r[k]  = AW'($urandom);
        im_r[k] = DW'($urandom);
        drive(k, op_r[k], d_r[k], im_r[k]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, op_r[k], d_r[k], im_r[k]);
      @(negedge clk);
      check_outs($sformatf("rnd_a[%0d]", n), 0, model_outs(0));
      check_outs($sformatf("rnd_b[%0d]", n), 1, model_outs(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mvi_ctrl.md
MVI_CTRL -- requirements
Module: mvi_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, immediate/data width in bits.
REQ-002 Parameter ADDR_W, default 3, destination register address width.
REQ-003 Parameter HOLD_CYC, default 3, busy-hold cycles after write, legal range 0..255.
REQ-004 Parameter OPC_MVI, default 4'b1100, opcode value that triggers a move-immediate.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 opcode  input  4  current instruction opcode, sampled every rising edge.
REQ-008 dest  input  ADDR_W  destination register address, sampled with opcode.
REQ-009 imm  input  DATA_W  immediate/memory data, sampled with opcode.
REQ-010 wr_en  output  1  register-file write strobe, one-cycle pulse.
REQ-011 wr_addr  output  ADDR_W  write address, valid while wr_en=1.
REQ-012 wr_data  output  DATA_W  write data, valid while wr_en=1.
REQ-013 busy  output  1  high while an accepted move is in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 drop  output  1  one-cycle pulse: a request was discarded.
REQ-016 pend  output  1  pending slot occupied; constant 0 when MVI_PENDING_EN is undefined.

Function
REQ-017 A request is any sampled edge with opcode==OPC_MVI; the block SHALL ignore all other opcodes.
REQ-018 The block SHALL implement states IDLE, LOAD, HOLD, DONE; all outputs SHALL be registered.
REQ-019 IDLE + request at edge N: SHALL capture dest/imm and enter LOAD; busy=1 from edge N.
REQ-020 LOAD: wr_en=1, wr_addr/wr_data = captured values, for exactly one cycle (edge N to N+1).
REQ-021 LOAD -> HOLD if HOLD_CYC>0, else LOAD -> DONE; HOLD SHALL last exactly HOLD_CYC cycles via a down-counter, then -> DONE.
REQ-022 DONE: done=1 and busy=0 for one cycle; busy SHALL be high for exactly 1+HOLD_CYC cycles per move.
REQ-023 DONE -> IDLE, unless a pending request exists (REQ-031), then DONE -> LOAD.
REQ-024 wr_addr/wr_data SHALL hold their last written values outside LOAD.
REQ-025 A request is sampled in IDLE only for acceptance; requests in LOAD/HOLD/DONE are handled by REQ-030..REQ-033.
REQ-026 Back-to-back requests held on opcode SHALL each be counted per edge (a level held for K edges is K requests).

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, wr_en=0, busy=0, done=0, drop=0, pend=0, wr_addr=0, wr_data=0.
REQ-028 Reset mid-operation SHALL abort the move with no wr_en or done pulse issued afterwards; pending request lost.
REQ-029 First request is accepted on the first rising edge with rst_n=1.

Configuration
REQ-030 Macro MVI_PENDING_EN undefined: every request arriving in LOAD/HOLD/DONE SHALL be discarded with drop=1 for one cycle.
REQ-031 MVI_PENDING_EN defined: a one-deep pending slot SHALL capture the first request arriving in LOAD/HOLD/DONE (pend=1); at DONE it SHALL be issued, entering LOAD on the next edge, pend cleared.
REQ-032 With MVI_PENDING_EN, a request arriving while pend=1 SHALL be dropped (drop=1), except in DONE while the slot drains, where it SHALL refill the slot (pend stays 1).
REQ-033 With MVI_PENDING_EN, pending issue SHALL keep busy=0 only in the DONE cycle, then busy=1 again from LOAD.

Verification
REQ-034 Reset, then opcode=1100, dest=5, imm=8'hA7 one cycle -> wr_en one cycle with wr_addr=5, wr_data=A7; busy 4 cycles; done one cycle later; back to IDLE.
REQ-035 opcode=0011 for 10 cycles -> no wr_en, busy, done or drop.
REQ-036 HOLD_CYC=0, single request dest=2, imm=8'h01 -> wr_en then done on consecutive cycles; busy exactly 1 cycle.
REQ-037 Macro undefined: request dest=1/imm=11, second request dest=3/imm=33 two cycles later -> only one write (1,11), drop pulses once.
REQ-038 Macro defined: same stimulus as REQ-037 -> pend=1, writes (1,11) then (3,33), two done pulses, no drop; third overlapping request dest=4/imm=44 during HOLD of first -> drop=1.
REQ-039 Request dest=6/imm=8'hFF, assert rst_n=0 during HOLD -> busy=0 immediately, no done, subsequent request after release completes normally.
